scope_mem_scheduler: RTL

Sequences the single-port sample RAM shared between scope capture and VGA display. During visible lines it issues look-ahead reads so a sample is presented in step with the pixel counters. During the lower blanking window it arms a level trigger on the ADC stream and writes one 640-sample trace per frame. It sits between the VGA timing generator's hcounter/vcounter, the ADC sample stream and the plot renderer.

---
 rtl/scope_mem_scheduler_pkg.sv | 31 +++
 rtl/scope_mem_scheduler_trigger.sv | 34 +++
 rtl/scope_mem_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/scope_mem_scheduler_pkg.sv
// rtl/scope_mem_scheduler_pkg.sv - timing, capture-window and state constants for the scope sample RAM path
// Purpose: constants shared by the scheduler, the VGA timing generator and the plot renderer.
// Contents: H/V timing, READ_LEAD, window decode constants, FSM state codes, window decode helper.
package scope_pkg;

    localparam logic [10:0] H_VISIBLE = 11'd640;
    localparam logic [10:0] H_TOTAL   = 11'd800;
    localparam logic [9:0]  V_VISIBLE = 10'd480;
    localparam logic [9:0]  V_TOTAL   = 10'd525;

    // Reads run this many columns ahead of the pixel counters to cover the RAM pipeline.
    localparam logic [10:0] READ_LEAD = 11'd3;

    // Capture window: lines V_VISIBLE..V_LAST, minus the last READ_LEAD columns of V_LAST,
    // which belong to the line-0 prefetch.
    localparam logic [9:0]  WIN_V_FIRST = V_VISIBLE;
    localparam logic [9:0]  V_LAST      = V_TOTAL - 10'd1;
    localparam logic [10:0] WIN_H_END   = H_TOTAL - READ_LEAD;
    localparam logic [10:0] WIN_H_LAST  = WIN_H_END - 11'd1;

    localparam logic [9:0]  TRACE_LAST  = 10'(H_VISIBLE - 11'd1);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_ARMED   = 2'd1;
    localparam logic [1:0]  ST_CAPTURE = 2'd2;

    function automatic logic in_window(input logic [10:0] h, input logic [9:0] v);
        return (v >= WIN_V_FIRST) && !((v == V_LAST) && (h >= WIN_H_END));
    endfunction

endpackage

// File: rtl/scope_mem_scheduler_trigger.sv
// rtl/scope_mem_scheduler_trigger.sv - rising-edge level trigger on the accepted ADC stream
// Purpose: holds the previous accepted sample and flags an upward crossing of the level.
// Ports: clk, reset (sync, active-high); clear_i drops the history; update_i stores sample_i;
//        sample_i/level_i compared unsigned; trig_o = have_prev && prev < level && sample >= level.
module scope_trigger #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          update_i,
    input  logic [DW-1:0] sample_i,
    input  logic [DW-1:0] level_i,
    output logic          trig_o
);

    logic [DW-1:0] prev_q;
    logic          have_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (clear_i) begin
            have_prev_q <= 1'b0;
        end else if (update_i) begin
            prev_q      <= sample_i;
            have_prev_q <= 1'b1;
        end
    end

    assign trig_o = have_prev_q && (prev_q < level_i) && (sample_i >= level_i);

endmodule

// File: rtl/scope_mem_scheduler.sv
// rtl/scope_mem_scheduler.sv - arbitrates the single-port sample RAM between display reads and trace capture
// Purpose: look-ahead display reads outside the capture window, one triggered 640-sample trace
//          written per frame inside it.
// Ports: clk, reset (sync, active-high); hcounter/vcounter from the timing generator;
//        run, trig_level, decim control; adc_data/adc_valid/adc_ready sample stream;
//        ram_addr/ram_we/ram_wdata/ram_rdata RAM port; disp_sample/disp_valid to the renderer;
//        frame_captured, trig_miss, overrun one-cycle status pulses.
module scope_mem_scheduler
    import scope_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   hcounter,
    input  logic [9:0]    vcounter,
    input  logic          run,
    input  logic [DW-1:0] trig_level,
    input  logic [3:0]    decim,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    output logic          adc_ready,
    output logic [9:0]    ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] disp_sample,
    output logic          disp_valid,
    output logic          frame_captured,
    output logic          trig_miss,
    output logic          overrun
);

    logic [1:0]    state_q, state_d;
    logic [9:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [3:0]    decim_q, decim_d;
    logic          cap_pend_q, cap_pend_d;
    logic [1:0]    rd_v_q;
    logic [9:0]    ram_addr_q, ram_addr_d, wr_addr_d;
    logic          ram_we_q, we_d;
    logic [DW-1:0] ram_wdata_q, wdata_d;
    logic [DW-1:0] disp_sample_q;
    logic          disp_valid_q, frame_captured_q;
    logic          trig_miss_q, trig_miss_d, overrun_q, overrun_d;
    logic          trig_clear, trig_update, trig_hit;

    // Window decode. w_last is the final window cycle: the FSM leaves on it and adc_ready is
    // already low, so nothing accepted there can produce a write outside the window.
    logic in_w, w_last, busy, leave, accept;
    assign in_w      = in_window(hcounter, vcounter);
    assign w_last    = (vcounter == V_LAST) && (hcounter == WIN_H_LAST);
    assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign leave     = busy && (!in_w || w_last);
    assign adc_ready = !reset && busy && in_w && !w_last;
    assign accept    = adc_valid && adc_ready;

    // Look-ahead read address: column READ_LEAD ahead, rolling onto the next line (and 524 -> 0).
    logic [10:0] rd_sum, rd_col;
    logic        rd_wrap, rd_en;
    logic [9:0]  rd_line;
    assign rd_sum  = hcounter + READ_LEAD;
    assign rd_wrap = rd_sum >= H_TOTAL;
    assign rd_col  = rd_wrap ? rd_sum - H_TOTAL : rd_sum;
    assign rd_line = !rd_wrap ? vcounter : ((vcounter == V_LAST) ? 10'd0 : vcounter + 10'd1);
    assign rd_en   = (rd_col < H_VISIBLE) && (rd_line < V_VISIBLE);

    scope_trigger #(.DW(DW)) u_trig (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (trig_clear),
        .update_i (trig_update),
        .sample_i (adc_data),
        .level_i  (trig_level),
        .trig_o   (trig_hit)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        dcnt_d      = dcnt_q;
        decim_d     = decim_q;
        cap_pend_d  = 1'b0;
        trig_miss_d = 1'b0;
        overrun_d   = 1'b0;
        trig_clear  = 1'b0;
        trig_update = 1'b0;
        we_d        = 1'b0;
        wr_addr_d   = wr_ptr_q;
        wdata_d     = ram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (run && (vcounter == WIN_V_FIRST) && (hcounter == 11'd0)) begin
                    state_d    = ST_ARMED;
                    trig_clear = 1'b1;
                    decim_d    = decim;
                end
            end
            ST_ARMED: begin
                if (leave) begin
                    state_d     = ST_IDLE;
                    trig_miss_d = 1'b1;
                end else if (accept) begin
                    trig_update = 1'b1;
                    if (trig_hit) begin
                        we_d      = 1'b1;
                        wr_addr_d = 10'd0;
                        wdata_d   = adc_data;
                        wr_ptr_d  = 10'd1;
                        dcnt_d    = decim_q;
                        state_d   = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (leave) begin
                    state_d   = ST_IDLE;
                    overrun_d = 1'b1;
                end else if (accept) begin
                    if (dcnt_q == 4'd0) begin
                        we_d     = 1'b1;
                        wdata_d  = adc_data;
                        wr_ptr_d = wr_ptr_q + 10'd1;
                        dcnt_d   = decim_q;
                        // frame_captured lands one cycle after this write appears on ram_we.
                        if (wr_ptr_q == TRACE_LAST) begin
                            state_d    = ST_IDLE;
                            cap_pend_d = 1'b1;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Writes and reads never overlap: writes only occur inside the window, reads only outside.
        ram_addr_d = we_d ? wr_addr_d : (rd_en ? rd_col[9:0] : ram_addr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            dcnt_q           <= '0;
            decim_q          <= '0;
            cap_pend_q       <= 1'b0;
            rd_v_q           <= '0;
            ram_addr_q       <= '0;
            ram_we_q         <= 1'b0;
            ram_wdata_q      <= '0;
            disp_sample_q    <= '0;
            disp_valid_q     <= 1'b0;
            frame_captured_q <= 1'b0;
            trig_miss_q      <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            dcnt_q           <= dcnt_d;
            decim_q          <= decim_d;
            cap_pend_q       <= cap_pend_d;
            rd_v_q           <= {rd_v_q[0], rd_en};
            ram_addr_q       <= ram_addr_d;
            ram_we_q         <= we_d;
            ram_wdata_q      <= wdata_d;
            disp_sample_q    <= ram_rdata;
            disp_valid_q     <= rd_v_q[1];
            frame_captured_q <= cap_pend_q;
            trig_miss_q      <= trig_miss_d;
            overrun_q        <= overrun_d;
        end
    end

    assign ram_addr       = ram_addr_q;
    assign ram_we         = ram_we_q;
    assign ram_wdata      = ram_wdata_q;
    assign disp_sample    = disp_sample_q;
    assign disp_valid     = disp_valid_q;
    assign frame_captured = frame_captured_q;
    assign trig_miss      = trig_miss_q;
    assign overrun        = overrun_q;

endmodule
